// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } dmem_state_t;

    localparam logic [3:0]  WE_NONE    = 4'b0000;
    localparam logic [3:0]  WE_WORD    = 4'b1111;
    localparam int unsigned BYTE_LANES = 4;

endpackage

// File: rtl/dmem_byte_lane.sv
// One byte lane of the data RAM: single write enable, registered read port.
module dmem_byte_lane #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);

    logic [7:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Write-through: a written lane returns the new byte, an untouched lane its stored byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with byte-lane writes and configurable wait states.
// Optional access counters enabled by defining DMEM_ACCESS_COUNT_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] wdata_in,
    input  logic [3:0]            write_enable,
    output logic [DATA_WIDTH-1:0] rdata_out,
    output logic                  ready,
    output logic                  busy,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_t           state, next_state;
    logic [3:0]            wait_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            we_q;
    logic                  access;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
            WAIT:    if (wait_cnt == '0) next_state = ACCESS;
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready    <= 1'b0;
            wait_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= WE_NONE;
        end else begin
            state <= next_state;
            // Registered so the pulse coincides exactly with the RESP state.
            ready <= (next_state == RESP);
            if (state == IDLE && req) begin
                addr_q   <= addr_in;
                wdata_q  <= wdata_in;
                we_q     <= write_enable;
                wait_cnt <= WAIT_LOAD;
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    assign busy   = (state != IDLE);
    assign access = (state == ACCESS);

    for (genvar i = 0; i < BYTE_LANES; i++) begin : g_lane
        dmem_byte_lane #(
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (access),
            .we    (we_q[i]),
            .addr  (addr_q),
            .wdata (wdata_q[8*i +: 8]),
            .rdata (rdata_out[8*i +: 8])
        );
    end

`ifdef DMEM_ACCESS_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (access) begin
            if (we_q == WE_NONE) begin
                if (rd_count != '1) rd_count <= rd_count + 32'd1;
            end else begin
                if (wr_count != '1) wr_count <= wr_count + 32'd1;
            end
        end
    end
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: one responder with no wait states, one with three.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req3 = 1'b0;
    logic [9:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  we = '0;

    logic [31:0] rdata0, rdata3, rd0, wr0, rd3, wr3;
    logic        ready0, ready3, busy0, busy3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .addr_in(addr), .wdata_in(wdata),
        .write_enable(we), .rdata_out(rdata0), .ready(ready0), .busy(busy0),
        .rd_count(rd0), .wr_count(wr0)
    );

    dmem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .addr_in(addr), .wdata_in(wdata),
        .write_enable(we), .rdata_out(rdata3), .ready(ready3), .busy(busy3),
        .rd_count(rd3), .wr_count(wr3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // One handshake; latency counts cycles after the sampling edge, busy cycles are tallied too.
    task automatic xact(input bit sel3, input logic [9:0] a, input logic [31:0] d,
                        input logic [3:0] e, input logic [31:0] exp_d, input int exp_lat,
                        input string tag);
        int lat;
        int busy_n;
        @(negedge clk);
        addr = a; wdata = d; we = e;
        if (sel3) req3 = 1'b1; else req0 = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        busy_n = (sel3 ? busy3 : busy0) ? 1 : 0;
        while (!(sel3 ? ready3 : ready0) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (sel3 ? busy3 : busy0) busy_n++;
        end
        req0 = 1'b0; req3 = 1'b0;
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy cycles"}, busy_n, exp_lat);
        check({tag, " rdata"}, sel3 ? rdata3 : rdata0, exp_d);
        @(posedge clk); #1;
        check({tag, " ready width"}, {31'b0, sel3 ? ready3 : ready0}, 32'd0);
        check({tag, " rdata held"}, sel3 ? rdata3 : rdata0, exp_d);
    endtask

    initial begin : main
        int pulses, bad_gap, last, exp_rd, exp_wr, seen;
        bit prev;

        #12;
        check("reset rdata0", rdata0, 32'h0);
        check("reset ready0", {31'b0, ready0}, 32'd0);
        check("reset busy0",  {31'b0, busy0}, 32'd0);
        check("reset rd0", rd0, 32'd0);
        check("reset wr0", wr0, 32'd0);
        check("reset busy3",  {31'b0, busy3}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        xact(1'b0, 10'd6, 32'h01234567, 4'b1111, 32'h01234567, 2, "w6");
        xact(1'b0, 10'd5, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 2, "w5 word");
        xact(1'b0, 10'd5, 32'h0,        4'b0000, 32'hDEADBEEF, 2, "r5 word");
        xact(1'b0, 10'd5, 32'hAAAAAAAA, 4'b0100, 32'hDEAABEEF, 2, "w5 lane2");
        xact(1'b0, 10'd5, 32'h0,        4'b0000, 32'hDEAABEEF, 2, "r5 lane2");
        xact(1'b0, 10'd6, 32'hFFFFFFFF, 4'b0000, 32'h01234567, 2, "r6 untouched");
        xact(1'b0, 10'd5, 32'h11223344, 4'b1001, 32'h11AABE44, 2, "w5 lanes03");
        xact(1'b0, 10'd5, 32'h0,        4'b0000, 32'h11AABE44, 2, "r5 lanes03");

        repeat (4) @(posedge clk);
        #1 check("rdata idle hold", rdata0, 32'h11AABE44);

        // req held: sampled at edges 1,4,..,16, dropped before the IDLE edge 19.
        @(negedge clk);
        addr = 10'd5; we = 4'b0000; req0 = 1'b1;
        pulses = 0; bad_gap = 0; last = -1; prev = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ready0) begin
                pulses++;
                if (prev) bad_gap++;
                if (last >= 0 && i - last != 3) bad_gap++;
                if (rdata0 !== 32'h11AABE44) bad_gap++;
                last = i;
            end
            prev = ready0;
            if (i == 17) req0 = 1'b0;
        end
        check("held req pulses", pulses, 6);
        check("held req spacing", bad_gap, 0);

`ifdef DMEM_ACCESS_COUNT_EN
        exp_rd = 10; exp_wr = 4;
`else
        exp_rd = 0; exp_wr = 0;
`endif
        check("rd_count", rd0, exp_rd);
        check("wr_count", wr0, exp_wr);

        xact(1'b1, 10'd9, 32'h00000000, 4'b1111, 32'h00000000, 5, "w3 clear9");
        xact(1'b1, 10'd9, 32'h0,        4'b0000, 32'h00000000, 5, "w3 r9");

        // Abort a write while it is still counting wait states.
        @(negedge clk);
        addr = 10'd9; wdata = 32'h12345678; we = 4'b1111; req3 = 1'b1;
        @(posedge clk); #1;
        req3 = 1'b0;
        check("abort busy", {31'b0, busy3}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort busy reset", {31'b0, busy3}, 32'd0);
        check("abort ready reset", {31'b0, ready3}, 32'd0);
        check("abort rdata reset", rdata3, 32'h0);
        check("reset clears rd0", rd0, 32'd0);
        check("reset clears wr0", wr0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ready3) seen++;
        end
        check("abort no ready", seen, 0);
        xact(1'b1, 10'd9, 32'h0, 4'b0000, 32'h00000000, 5, "abort r9");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
